time_set_ctrl: RTL and testbench

//  Timekeeping controller for the digital clock. Advances HH:MM:SS on the 1 Hz enable from the clock divider.

---
 rtl/clock_pkg.sv | 21 ++
 rtl/time_set_ctrl_if.sv | 27 ++
 rtl/mod_counter.sv | 44 ++++
 rtl/time_set_ctrl.sv | 123 ++++++++++++
 tb/tb_time_set_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared encodings and field constants for the digital clock timekeeping and display logic.
package clock_pkg;

    // Operating mode, also driven straight out as the 2-bit mode field.
    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10
    } mode_e;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HR24_MOD = 24;
    localparam int HR12_MOD = 12;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HR_W   = 5;
    localparam int MODE_W = 2;

endpackage

// File: rtl/time_set_ctrl_if.sv
// Strobe inputs and time/mode/blank outputs of the timekeeping controller.
interface time_set_ctrl_if;
    import clock_pkg::*;

    logic              tick_1hz;
    logic              btn_mode;
    logic              btn_inc;
    logic [HR_W-1:0]   hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
    logic [MODE_W-1:0] mode;
    logic              blank_hr;
    logic              blank_min;

    // Source of strobes, consumer of the time display fields.
    modport master (
        output tick_1hz, btn_mode, btn_inc,
        input  hours, minutes, seconds, mode, blank_hr, blank_min
    );

    // The controller itself.
    modport slave (
        input  tick_1hz, btn_mode, btn_inc,
        output hours, minutes, seconds, mode, blank_hr, blank_min
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo counter over MIN_VAL..MIN_VAL+MODULO-1 with clear and a same-cycle wrap flag.
module mod_counter #(
    parameter int MODULO  = 60,
    parameter int MIN_VAL = 0,
    parameter int WIDTH   = 6,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] FIRST = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MIN_VAL + MODULO - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] value_d, value_q;

    // Wrap is combinational so the caller can chain the carry into the next field on the same edge.
    assign wrap  = inc & (value_q == LAST);
    assign value = value_q;

    // Next value: clear dominates, otherwise step with wrap back to the first value.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = FIRST;
        end else if (inc) begin
            value_d = (value_q == LAST) ? FIRST : value_q + WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= RST_V;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Timekeeping controller: HH:MM:SS advance on the 1 Hz strobe, set-mode FSM, blink and auto-return timeout.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter bit H12       = 1'b0,
    parameter int TIMEOUT_S = 30
) (
    input  logic            clk,
    input  logic            rst,
    time_set_ctrl_if.slave  bus
);
    localparam int HR_MOD = H12 ? HR12_MOD : HR24_MOD;
    localparam int HR_MIN = H12 ? 1 : 0;
    localparam int HR_RST = H12 ? HR12_MOD : 0;
    localparam int TMO_W  = $clog2(TIMEOUT_S + 1);
    // Count value on which the next set-state tick completes the timeout.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_S - 1);

    mode_e            state_d, state_q;
    logic             blink_d, blink_q;
    logic [TMO_W-1:0] tmo_d, tmo_q;
    logic             blank_hr_d, blank_hr_q;
    logic             blank_min_d, blank_min_q;

    logic             field_inc;
    logic             sec_clr;
    logic             in_run;
    logic             sec_inc, min_inc, hr_inc;
    logic             sec_wrap, min_wrap, hr_wrap_unused;
    logic [SEC_W-1:0] sec_val;
    logic [MIN_W-1:0] min_val;
    logic [HR_W-1:0]  hr_val;

    // Counter enables: time only runs in RUN with carries chained; set states edit one field, no carry.
    assign in_run  = (state_q == MODE_RUN);
    assign sec_inc = in_run & bus.tick_1hz;
    assign min_inc = (in_run & sec_wrap) | (field_inc & (state_q == MODE_SET_MIN));
    assign hr_inc  = (in_run & min_wrap) | (field_inc & (state_q == MODE_SET_HR));

    mod_counter #(.MODULO(SEC_MOD), .MIN_VAL(0), .WIDTH(SEC_W), .RST_VAL(0)) u_sec (
        .clk(clk), .rst(rst), .inc(sec_inc), .clr(sec_clr), .value(sec_val), .wrap(sec_wrap)
    );

    mod_counter #(.MODULO(MIN_MOD), .MIN_VAL(0), .WIDTH(MIN_W), .RST_VAL(0)) u_min (
        .clk(clk), .rst(rst), .inc(min_inc), .clr(1'b0), .value(min_val), .wrap(min_wrap)
    );

    mod_counter #(.MODULO(HR_MOD), .MIN_VAL(HR_MIN), .WIDTH(HR_W), .RST_VAL(HR_RST)) u_hr (
        .clk(clk), .rst(rst), .inc(hr_inc), .clr(1'b0), .value(hr_val), .wrap(hr_wrap_unused)
    );

    // Mode/blink/timeout next state; btn_mode beats btn_inc, which beats tick_1hz in set states.
    always_comb begin
        state_d   = state_q;
        blink_d   = blink_q;
        tmo_d     = tmo_q;
        field_inc = 1'b0;
        sec_clr   = 1'b0;
        case (state_q)
            MODE_RUN: begin
                if (bus.btn_mode) begin
                    state_d = MODE_SET_HR;
                    blink_d = 1'b0;
                    tmo_d   = '0;
                end
            end
            MODE_SET_HR, MODE_SET_MIN: begin
                if (bus.btn_mode) begin
                    state_d = (state_q == MODE_SET_HR) ? MODE_SET_MIN : MODE_RUN;
                    sec_clr = (state_q == MODE_SET_MIN);
                    blink_d = 1'b0;
                    tmo_d   = '0;
                end else if (bus.btn_inc) begin
                    field_inc = 1'b1;
                    blink_d   = 1'b0;
                    tmo_d     = '0;
                end else if (bus.tick_1hz) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = MODE_RUN;
                        sec_clr = 1'b1;
                        blink_d = 1'b0;
                        tmo_d   = '0;
                    end else begin
                        blink_d = ~blink_q;
                        tmo_d   = tmo_q + TMO_W'(1);
                    end
                end
            end
            default: begin
                state_d = MODE_RUN;
                blink_d = 1'b0;
                tmo_d   = '0;
            end
        endcase
        blank_hr_d  = (state_d == MODE_SET_HR)  & blink_d;
        blank_min_d = (state_d == MODE_SET_MIN) & blink_d;
    end

    // FSM, blink phase, timeout count and registered blank strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MODE_RUN;
            blink_q     <= 1'b0;
            tmo_q       <= '0;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_q     <= blink_d;
            tmo_q       <= tmo_d;
            blank_hr_q  <= blank_hr_d;
            blank_min_q <= blank_min_d;
        end
    end

    assign bus.hours     = hr_val;
    assign bus.minutes   = min_val;
    assign bus.seconds   = sec_val;
    assign bus.mode      = state_q;
    assign bus.blank_hr  = blank_hr_q;
    assign bus.blank_min = blank_min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a 24-hour/3 s-timeout instance and a 12-hour/30 s-timeout instance on shared stimulus.
module tb_time_set_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, tick = 1'b0, bm = 1'b0, bi = 1'b0;

    time_set_ctrl_if ifa ();
    time_set_ctrl_if ifb ();

    assign ifa.tick_1hz = tick;
    assign ifa.btn_mode = bm;
    assign ifa.btn_inc  = bi;
    assign ifb.tick_1hz = tick;
    assign ifb.btn_mode = bm;
    assign ifb.btn_inc  = bi;

    time_set_ctrl #(.H12(1'b0), .TIMEOUT_S(3))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
    time_set_ctrl #(.H12(1'b1), .TIMEOUT_S(30)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int errors = 0;
    int checks = 0;

    // Reference model: clock face as plain integers, mode 0/1/2, blink phase and ticks seen while editing.
    typedef struct {
        int h; int m; int s; int mode; int blink; int tmo;
    } mdl_t;

    mdl_t ma, mb;

    function automatic int hr_next(int h, bit h12);
        return h12 ? (h % 12) + 1 : (h + 1) % 24;
    endfunction

    function automatic mdl_t mdl_step(mdl_t x, bit h12, int tmax, bit r, bit t, bit mo, bit in);
        mdl_t y = x;
        if (r) begin
            y.h = h12 ? 12 : 0; y.m = 0; y.s = 0; y.mode = 0; y.blink = 0; y.tmo = 0;
            return y;
        end
        if (x.mode == 0) begin
            if (t) begin
                y.s = (x.s + 1) % 60;
                if (y.s == 0) begin
                    y.m = (x.m + 1) % 60;
                    if (y.m == 0) y.h = hr_next(x.h, h12);
                end
            end
            if (mo) begin y.mode = 1; y.blink = 0; y.tmo = 0; end
        end else if (mo) begin
            y.mode = (x.mode == 1) ? 2 : 0;
            if (x.mode == 2) y.s = 0;
            y.blink = 0; y.tmo = 0;
        end else if (in) begin
            if (x.mode == 1) y.h = hr_next(x.h, h12);
            else             y.m = (x.m + 1) % 60;
            y.blink = 0; y.tmo = 0;
        end else if (t) begin
            y.tmo   = x.tmo + 1;
            y.blink = (x.blink == 0) ? 1 : 0;
            if (y.tmo == tmax) begin
                y.mode = 0; y.s = 0; y.tmo = 0; y.blink = 0;
            end
        end
        return y;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_mdl(string tag, int h, int m, int s, int mo, int bh, int bmn, mdl_t x);
        chk({tag, ".hours"},     h,   x.h);
        chk({tag, ".minutes"},   m,   x.m);
        chk({tag, ".seconds"},   s,   x.s);
        chk({tag, ".mode"},      mo,  x.mode);
        chk({tag, ".blank_hr"},  bh,  (x.mode == 1 && x.blink != 0) ? 1 : 0);
        chk({tag, ".blank_min"}, bmn, (x.mode == 2 && x.blink != 0) ? 1 : 0);
    endtask

    // One clock with the given strobes; both DUTs are compared with their models after the edge.
    task automatic step(bit r, bit t, bit mo, bit in);
        rst = r; tick = t; bm = mo; bi = in;
        @(posedge clk);
        #1;
        rst = 1'b0; tick = 1'b0; bm = 1'b0; bi = 1'b0;
        ma = mdl_step(ma, 1'b0, 3,  r, t, mo, in);
        mb = mdl_step(mb, 1'b1, 30, r, t, mo, in);
        cmp_mdl("mdl_a", int'(ifa.hours), int'(ifa.minutes), int'(ifa.seconds), int'(ifa.mode),
                int'(ifa.blank_hr), int'(ifa.blank_min), ma);
        cmp_mdl("mdl_b", int'(ifb.hours), int'(ifb.minutes), int'(ifb.seconds), int'(ifb.mode),
                int'(ifb.blank_hr), int'(ifb.blank_min), mb);
    endtask

    task automatic stepn(int n, bit r, bit t, bit mo, bit in);
        for (int k = 0; k < n; k++) step(r, t, mo, in);
    endtask

    // Directed vector: repeat the strobes n cycles, then the 24-hour instance must show the expected face.
    typedef struct {
        int n; bit r; bit t; bit mo; bit in;
        int h; int m; int s; int mode; int bh; int bmn;
    } vec_t;

    vec_t vt[$];

    task automatic add(int n, bit r, bit t, bit mo, bit in, int h, int m, int s, int mode, int bh, int bmn);
        vec_t v;
        v.n = n; v.r = r; v.t = t; v.mo = mo; v.in = in;
        v.h = h; v.m = m; v.s = s; v.mode = mode; v.bh = bh; v.bmn = bmn;
        vt.push_back(v);
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};

        //      n   r t mo in   h  m  s  mode bh bmn
        add(1,  1,0,0,0,   0, 0, 0, 0, 0, 0);   // reset state
        add(1,  0,0,1,0,   0, 0, 0, 1, 0, 0);   // enter SET_HR
        add(23, 0,0,0,1,  23, 0, 0, 1, 0, 0);
        add(1,  0,0,1,0,  23, 0, 0, 2, 0, 0);
        add(59, 0,0,0,1,  23,59, 0, 2, 0, 0);
        add(1,  0,0,1,0,  23,59, 0, 0, 0, 0);
        add(58, 0,1,0,0,  23,59,58, 0, 0, 0);
        add(1,  0,1,0,0,  23,59,59, 0, 0, 0);   // rollover, first tick
        add(1,  0,1,0,0,   0, 0, 0, 0, 0, 0);   // full-day wrap in one edge
        add(1,  0,0,1,0,   0, 0, 0, 1, 0, 0);
        add(1,  0,0,1,1,   0, 0, 0, 2, 0, 0);   // mode+inc: increment dropped
        add(1,  0,0,1,0,   0, 0, 0, 0, 0, 0);
        add(59, 0,1,0,0,   0, 0,59, 0, 0, 0);
        add(1,  0,1,1,0,   0, 1, 0, 1, 0, 0);   // tick+mode in RUN: both applied
        add(1,  0,1,0,0,   0, 1, 0, 1, 1, 0);   // blink on
        add(1,  0,1,0,1,   1, 1, 0, 1, 0, 0);   // tick+inc: button wins
        add(1,  0,1,0,0,   1, 1, 0, 1, 1, 0);
        add(1,  0,1,0,0,   1, 1, 0, 1, 0, 0);
        add(1,  0,1,0,0,   1, 1, 0, 0, 0, 0);   // timeout from SET_HR
        add(5,  0,1,0,0,   1, 1, 5, 0, 0, 0);
        add(1,  0,0,1,0,   1, 1, 5, 1, 0, 0);
        add(1,  0,0,1,0,   1, 1, 5, 2, 0, 0);
        add(1,  0,1,0,0,   1, 1, 5, 2, 0, 1);   // blank_min toggles 1
        add(1,  0,1,0,0,   1, 1, 5, 2, 0, 0);   // then 0
        add(1,  0,1,0,0,   1, 1, 0, 0, 0, 0);   // third tick: timeout, seconds cleared
        add(7,  0,1,0,0,   1, 1, 7, 0, 0, 0);
        add(2,  0,0,1,0,   1, 1, 7, 2, 0, 0);
        add(1,  0,1,0,0,   1, 1, 7, 2, 0, 1);
        add(1,  0,1,1,0,   1, 1, 0, 0, 0, 0);   // tick+mode in SET_MIN: to RUN, seconds 0
        add(2,  0,0,1,0,   1, 1, 0, 2, 0, 0);
        add(59, 0,0,0,1,   1, 0, 0, 2, 0, 0);   // minute wrap, no hour carry
        add(1,  0,1,0,0,   1, 0, 0, 2, 0, 1);
        add(1,  1,1,0,0,   0, 0, 0, 0, 0, 0);   // reset mid-edit, tick ignored
        add(1,  0,0,0,0,   0, 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            stepn(vt[i].n, vt[i].r, vt[i].t, vt[i].mo, vt[i].in);
            chk($sformatf("vec%0d.hours", i),     int'(ifa.hours),     vt[i].h);
            chk($sformatf("vec%0d.minutes", i),   int'(ifa.minutes),   vt[i].m);
            chk($sformatf("vec%0d.seconds", i),   int'(ifa.seconds),   vt[i].s);
            chk($sformatf("vec%0d.mode", i),      int'(ifa.mode),      vt[i].mode);
            chk($sformatf("vec%0d.blank_hr", i),  int'(ifa.blank_hr),  vt[i].bh);
            chk($sformatf("vec%0d.blank_min", i), int'(ifa.blank_min), vt[i].bmn);
        end

        // 12-hour wrap on the H12 instance.
        step(1, 0, 0, 0);
        chk("h12.reset_hours", int'(ifb.hours), 12);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("h12.inc_hours", int'(ifb.hours), 1);
        stepn(11, 0, 0, 0, 1);
        chk("h12.wrap_hours", int'(ifb.hours), 12);
        chk("h12.minutes", int'(ifb.minutes), 0);
        chk("h12.seconds", int'(ifb.seconds), 0);
        stepn(2, 0, 0, 1, 0);

        // Set path on the 24-hour instance starting from 10:20:37.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        stepn(10, 0, 0, 0, 1);
        step(0, 0, 1, 0);
        stepn(20, 0, 0, 0, 1);
        step(0, 0, 1, 0);
        stepn(37, 0, 1, 0, 0);
        chk("set.start_h", int'(ifa.hours), 10);
        chk("set.start_m", int'(ifa.minutes), 20);
        chk("set.start_s", int'(ifa.seconds), 37);
        step(0, 0, 1, 0);
        stepn(3, 0, 0, 0, 1);
        chk("set.hours13", int'(ifa.hours), 13);
        step(0, 0, 1, 0);
        stepn(45, 0, 0, 0, 1);
        chk("set.minutes5", int'(ifa.minutes), 5);
        chk("set.hours_kept", int'(ifa.hours), 13);
        step(0, 0, 1, 0);
        chk("set.run_mode", int'(ifa.mode), 0);
        chk("set.run_s", int'(ifa.seconds), 0);
        step(0, 1, 0, 0);
        chk("set.next_tick_s", int'(ifa.seconds), 1);
        chk("set.next_tick_m", int'(ifa.minutes), 5);

        // Random strobes against the models.
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
